// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Shared definitions for the bit-serial adder:
//     - state encoding constants and the FSM state type
//     - default operand width
//     - clog2 helper used to size the bit counter
//   Optional feature macro used by the top level: SERIAL_ADD_OVF_EN
// ---------------------------------------------------------------------------
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Number of bits needed to count 0..value-1.
  // Never returns less than 1, so a counter port is never zero-width.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_full_adder_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   Combinational 1-bit full adder cell used by the serial adder.
//   Ports:
//     a, b   in  1  operand bits
//     c      in  1  carry-in bit
//     sum    out 1  a ^ b ^ c
//     carry  out 1  carry-out
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  // Propagate/generate form of the carry.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (c & (a ^ b));
  end

endmodule

// File: rtl/serial_full_adder.sv
// ---------------------------------------------------------------------------
// serial_full_adder
//   Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
//   built around a single full_adder cell and a carry flip-flop.
//   Handshake: start is only accepted in IDLE; done pulses for one cycle
//   when sum/cout are valid. Results hold until the next accepted start.
//
//   Parameters:
//     W      operand/result width (W >= 2)
//   Ports:
//     clk    in   1  clock, rising edge
//     rst    in   1  synchronous reset, active-high
//     start  in   1  request, sampled only in IDLE
//     a, b   in   W  operands, captured on an accepted start
//     cin    in   1  carry-in, captured on an accepted start
//     busy   out  1  high while bits are being processed
//     done   out  1  one-cycle result-valid pulse
//     sum    out  W  result
//     cout   out  1  final carry-out
//     ovf    out  1  signed overflow (only when SERIAL_ADD_OVF_EN is defined)
// ---------------------------------------------------------------------------
module serial_full_adder
  import serial_add_pkg::*;
#(
  parameter int W = SA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = clog2(W);

  state_t        state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          fa_sum;
  logic          fa_carry;

  full_adder u_full_adder (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Single FSM block. All outputs are registered here. The last bit is
  // processed on the edge that leaves RUN, so done/cout/ovf are loaded on
  // that same edge and are valid while the FSM sits in DONE. The DONE state
  // itself only burns one cycle so a start raised alongside done is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            sum   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          // New bit enters at the MSB; after W shifts bit 0 is the LSB.
          sum   <= {fa_sum, sum[W-1:1]};
          carry <= fa_carry;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB at this point.
            ovf   <= carry ^ fa_carry;
`endif
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_full_adder
//   Self-checking bench for serial_full_adder (W=8). Directed vectors from a
//   table, hand-written handshake/reset sequences, and random operands checked
//   against plain integer arithmetic. Define SERIAL_ADD_OVF_EN to also check
//   the signed overflow output.
// ---------------------------------------------------------------------------
module tb_serial_full_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks;
  int errors;

  serial_full_adder #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  // Compare one value and report on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse start with the given operands, then wait (bounded) for done.
  // lat counts negedges after the accepting edge; done is expected at W+1.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tc, output int lat,
                               output int busy_cnt);
    @(negedge clk);
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < W + 10) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Reference: signed overflow from plain integer arithmetic.
  function automatic logic ref_ovf(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc);
    int s;
    s = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    return (s > 127) || (s < -128);
  endfunction

  initial begin
    vec_t         vecs[7];
    int           lat;
    int           busy_cnt;
    int           dones;
    logic [W:0]   got;
    logic [W:0]   exp9;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("reset_ovf", ovf, 0);
`endif

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat, busy_cnt);
      checkOutput($sformatf("vec%0d_latency", i), lat, W + 1);
      checkOutput($sformatf("vec%0d_busy_cycles", i), busy_cnt, W);
      checkOutput($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
`ifdef SERIAL_ADD_OVF_EN
      checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), done, 0);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("vec%0d_hold", i), {cout, sum}, {vecs[i].cout, vecs[i].sum});
    end

    // Second start during RUN is ignored; exactly one done pulse.
    @(negedge clk);
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    got   = '0;
    for (int k = 1; k <= W + 6; k++) begin
      if (k == 3) begin
        a     = 8'hF0;
        b     = 8'h0F;
        cin   = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        got = {cout, sum};
      end
      @(negedge clk);
    end
    checkOutput("ignore_run_done_count", dones, 1);
    checkOutput("ignore_run_result", got, 9'h046);

    // Start raised while done is high is ignored.
    applyStimulus(8'h01, 8'h02, 1'b0, lat, busy_cnt);
    checkOutput("done_start_latency", lat, W + 1);
    a     = 8'h55;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_start_busy", busy, 0);
    @(negedge clk);
    checkOutput("done_start_busy2", busy, 0);
    checkOutput("done_start_hold", {cout, sum}, 9'h003);

    // Reset in the middle of RUN.
    @(negedge clk);
    a     = 8'hC3;
    b     = 8'h3C;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput("midrst_ovf", ovf, 0);
`endif
    dones = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", dones, 0);
    applyStimulus(8'hC3, 8'h3C, 1'b1, lat, busy_cnt);
    checkOutput("after_rst_latency", lat, W + 1);
    checkOutput("after_rst_result", {cout, sum}, 9'h100);

    // Random operands against integer arithmetic.
    for (int n = 0; n < 2000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      exp9 = (W + 1)'(int'(ra) + int'(rb) + int'(rc));
      applyStimulus(ra, rb, rc, lat, busy_cnt);
      if (lat != W + 1) checkOutput($sformatf("rand%0d_latency", n), lat, W + 1);
      checkOutput($sformatf("rand%0d_sum", n), {cout, sum}, exp9);
`ifdef SERIAL_ADD_OVF_EN
      checkOutput($sformatf("rand%0d_ovf", n), ovf, ref_ovf(ra, rb, rc));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
